// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, samples the combinational memory word and presents
// {inst, inst_pc} through a valid/ready slot. Optional HALT_DETECT_EN stops on all-zero words.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_write,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // state  | meaning
  // RUN    | fetching one word per cycle when the output slot allows
  // FAULT  | PC ran past memory; waits for redirect
  // HALTED | zero word seen (HALT_DETECT_EN only); waits for redirect
`ifdef HALT_DETECT_EN
  typedef enum logic [1:0] {RUN = 2'd0, FAULT = 2'd1, HALTED = 2'd2} state_t;
`else
  typedef enum logic [0:0] {RUN = 1'b0, FAULT = 1'b1} state_t;
`endif

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        valid_next, fault_next, load_inst;
  logic        fire, can_take, in_range;

  assign fire     = inst_valid && inst_ready;
  assign can_take = !stall && (!inst_valid || inst_ready);
  // 33-bit sum so a PC near the top of the address space cannot wrap into range
  assign in_range = ({1'b0, pc} + 33'd3) < 33'(MEM_BYTES);

  assign imem_addr  = pc;
  assign imem_write = 1'b0;
  assign imem_wdata = 32'h0000_0000;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = fire ? 1'b0 : inst_valid;
    fault_next = fault;
    load_inst  = 1'b0;
    if (redirect_valid) begin
      pc_next    = redirect_pc & ~32'h3;
      valid_next = 1'b0;
      state_next = RUN;
      fault_next = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (can_take) begin
            if (!in_range) begin
              state_next = FAULT;
              fault_next = 1'b1;
            end else begin
`ifdef HALT_DETECT_EN
              if (imem_rdata == 32'h0000_0000) begin
                state_next = HALTED;
                valid_next = 1'b0;
              end else begin
                load_inst  = 1'b1;
                valid_next = 1'b1;
                pc_next    = pc + 32'd4;
              end
`else
              load_inst  = 1'b1;
              valid_next = 1'b1;
              pc_next    = pc + 32'd4;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inst        <= 32'h0000_0000;
      inst_pc     <= 32'h0000_0000;
      inst_valid  <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 32'h0000_0000;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      inst_valid <= valid_next;
      fault      <= fault_next;
      if (load_inst) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
      if (fire) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: run, backpressure, stall, redirect, range fault, zero word.
// Build with +define+HALT_DETECT_EN to check the halting variant of the zero-word case.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_write;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fault;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0), .MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_write(imem_write), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .fault(fault), .fetch_count(fetch_count)
  );

  // memory image: a few named words, a zero word at 0x200, address-tagged elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h000: return 32'h0000_00A1;
      32'h004: return 32'h0000_00B2;
      32'h008: return 32'h0000_00C3;
      32'h200: return 32'h0000_0000;
      default: return 32'h1000_0000 | a;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] i,
                           input logic [31:0] ipc, input logic [31:0] addr,
                           input logic [31:0] cnt);
    check_eq({tag, ".valid"}, 32'(inst_valid), 32'(v));
    if (v) begin
      check_eq({tag, ".inst"}, inst, i);
      check_eq({tag, ".inst_pc"}, inst_pc, ipc);
    end
    check_eq({tag, ".addr"}, imem_addr, addr);
    check_eq({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    step(); step();
    check_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_eq("reset.fault", 32'(fault), 32'h0);
    check_eq("reset.write", 32'(imem_write), 32'h0);
    check_eq("reset.wdata", imem_wdata, 32'h0);

    // T1: one-cycle latency, full throughput
    reset = 1'b0;
    step(); check_out("t1_0", 1'b1, 32'hA1, 32'h0, 32'h4, 32'd0);
    step(); check_out("t1_1", 1'b1, 32'hB2, 32'h4, 32'h8, 32'd1);
    step(); check_out("t1_2", 1'b1, 32'hC3, 32'h8, 32'hC, 32'd2);

    // T2: backpressure holds the slot and the PC
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); check_out("t2_hold", 1'b1, 32'hC3, 32'h8, 32'hC, 32'd2);
    end
    inst_ready = 1'b1;
    step(); check_out("t2_resume", 1'b1, 32'h1000_000C, 32'hC, 32'h10, 32'd3);

    // T3: stall freezes PC; pending word still drains
    stall = 1'b1;
    step(); check_out("t3_drain", 1'b0, 32'h0, 32'h0, 32'h10, 32'd4);
    step(); check_out("t3_hold", 1'b0, 32'h0, 32'h0, 32'h10, 32'd4);
    stall = 1'b0;
    step(); check_out("t3_res0", 1'b1, 32'h1000_0010, 32'h10, 32'h14, 32'd4);
    step(); check_out("t3_res1", 1'b1, 32'h1000_0014, 32'h14, 32'h18, 32'd5);

    // T4: redirect with simultaneous handshake, unaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step(); check_out("t4_redir", 1'b0, 32'h0, 32'h0, 32'h100, 32'd6);
    redirect_valid = 1'b0;
    step(); check_out("t4_first", 1'b1, 32'h1000_0100, 32'h100, 32'h104, 32'd6);

    // T5: run off the end of memory
    redirect_valid = 1'b1; redirect_pc = 32'h3F8;
    step(); check_out("t5_redir", 1'b0, 32'h0, 32'h0, 32'h3F8, 32'd7);
    redirect_valid = 1'b0;
    step(); check_out("t5_3f8", 1'b1, 32'h1000_03F8, 32'h3F8, 32'h3FC, 32'd7);
    step(); check_out("t5_3fc", 1'b1, 32'h1000_03FC, 32'h3FC, 32'h400, 32'd8);
    check_eq("t5_pre.fault", 32'(fault), 32'h0);
    step(); check_out("t5_fault", 1'b0, 32'h0, 32'h0, 32'h400, 32'd9);
    check_eq("t5_fault.fault", 32'(fault), 32'h1);
    step(); check_out("t5_sticky", 1'b0, 32'h0, 32'h0, 32'h400, 32'd9);
    check_eq("t5_sticky.fault", 32'(fault), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h0; stall = 1'b1;
    step(); check_out("t5_clear", 1'b0, 32'h0, 32'h0, 32'h0, 32'd9);
    check_eq("t5_clear.fault", 32'(fault), 32'h0);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); check_out("t5_resume", 1'b1, 32'hA1, 32'h0, 32'h4, 32'd9);

    // T6: zero word at 0x200
    redirect_valid = 1'b1; redirect_pc = 32'h1F8;
    step(); check_out("t6_redir", 1'b0, 32'h0, 32'h0, 32'h1F8, 32'd10);
    redirect_valid = 1'b0;
    step(); check_out("t6_1f8", 1'b1, 32'h1000_01F8, 32'h1F8, 32'h1FC, 32'd10);
    step(); check_out("t6_1fc", 1'b1, 32'h1000_01FC, 32'h1FC, 32'h200, 32'd11);
`ifdef HALT_DETECT_EN
    step(); check_out("t6_halt", 1'b0, 32'h0, 32'h0, 32'h200, 32'd12);
    step(); check_out("t6_halted", 1'b0, 32'h0, 32'h0, 32'h200, 32'd12);
`else
    step(); check_out("t6_zero", 1'b1, 32'h0, 32'h200, 32'h204, 32'd12);
    step(); check_out("t6_next", 1'b1, 32'h1000_0204, 32'h204, 32'h208, 32'd13);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
